// File: rtl/multiplicador_param.sv
// -----------------------------------------------------------------------------
// multiplicador_param
//   Sequential shift-add multiplier with optional two's-complement operands.
//   The multiplier uses the operand magnitudes and fixes the sign at the end.
//   An accepted init produces a result a fixed WIDTH+1 cycles later.
//
// Parameters
//   WIDTH      operand width in bits (2..32)
//
// Ports
//   clk        clock, rising edge active
//   rst        asynchronous active-high reset
//   init       start request; accepted in IDLE or DONE only
//   sign_mode  0 = unsigned operands, 1 = two's-complement operands
//   MR         multiplier operand
//   MD         multiplicand operand
//   pp         product register (2*WIDTH bits), valid while done is high
//   done       result valid, held until the next accepted init or reset
//   busy       operation in progress (RUN and FIX states)
// -----------------------------------------------------------------------------
module multiplicador_param #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 sign_mode,
    input  logic [WIDTH-1:0]     MR,
    input  logic [WIDTH-1:0]     MD,
    output logic [2*WIDTH-1:0]   pp,
    output logic                 done,
    output logic                 busy
);

    // Counter must be able to hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   pp_q,    pp_d;
    logic [2*WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]     b_q,     b_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic                 sign_q,  sign_d;
    logic                 done_q,  done_d;
    logic                 busy_q,  busy_d;

    logic [WIDTH-1:0]     mr_mag;
    logic [WIDTH-1:0]     md_mag;

    // Negating the most-negative value wraps back to itself, which read as
    // unsigned is exactly 2^(WIDTH-1): the correct magnitude.
    assign mr_mag = (sign_mode && MR[WIDTH-1]) ? -MR : MR;
    assign md_mag = (sign_mode && MD[WIDTH-1]) ? -MD : MD;

    always_comb begin
        // NOTE: every _d signal gets a hold default before the case so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        pp_d    = pp_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        done_d  = done_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE, DONE: begin
                if (init) begin
                    a_d     = {{WIDTH{1'b0}}, md_mag};
                    b_d     = mr_mag;
                    sign_d  = sign_mode & (MR[WIDTH-1] ^ MD[WIDTH-1]);
                    pp_d    = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
                end
            end

            RUN: begin
                // Fixed WIDTH iterations; no early exit even when B runs out
                // of set bits, so latency never depends on operand values.
                if (b_q[0]) begin
                    pp_d = pp_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                // Negating zero yields zero, so no negative-zero case exists.
                if (sign_q) begin
                    pp_d = -pp_q;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their _d values from the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pp_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pp_q    <= pp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign pp   = pp_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_multiplicador_param.sv
// -----------------------------------------------------------------------------
// tb_multiplicador_param
//   Directed self-checking bench for multiplicador_param. A WIDTH=4 instance
//   covers the functional, reset and protocol cases including an exhaustive
//   operand sweep; a WIDTH=8 instance covers the wider boundary products.
// -----------------------------------------------------------------------------
module tb_multiplicador_param;

    logic        clk = 1'b0;
    logic        rst;

    logic        init4, sm4;
    logic [3:0]  mr4, md4;
    logic [7:0]  pp4;
    logic        done4, busy4;

    logic        init8, sm8;
    logic [7:0]  mr8, md8;
    logic [15:0] pp8;
    logic        done8, busy8;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    multiplicador_param #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .init      (init4),
        .sign_mode (sm4),
        .MR        (mr4),
        .MD        (md4),
        .pp        (pp4),
        .done      (done4),
        .busy      (busy4)
    );

    multiplicador_param #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .init      (init8),
        .sign_mode (sm8),
        .MR        (mr8),
        .MD        (md8),
        .pp        (pp8),
        .done      (done8),
        .busy      (busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference product for 4-bit operands, computed with integer arithmetic.
    function automatic logic [7:0] ref4(input logic sm, input logic [3:0] mr, input logic [3:0] md);
        int a;
        int b;
        a = (sm && mr[3]) ? int'(mr) - 16 : int'(mr);
        b = (sm && md[3]) ? int'(md) - 16 : int'(md);
        return 8'(a * b);
    endfunction

    // One-cycle init pulse, then count negedges until done (bounded).
    task automatic run4(input logic sm, input logic [3:0] mr, input logic [3:0] md, output int l);
        @(negedge clk);
        sm4 = sm; mr4 = mr; md4 = md; init4 = 1'b1;
        @(negedge clk);
        init4 = 1'b0;
        l = 0;
        while (!done4 && l < 20) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run8(input logic sm, input logic [7:0] mr, input logic [7:0] md, output int l);
        @(negedge clk);
        sm8 = sm; mr8 = mr; md8 = md; init8 = 1'b1;
        @(negedge clk);
        init8 = 1'b0;
        l = 0;
        while (!done8 && l < 30) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        init4 = 1'b0; sm4 = 1'b0; mr4 = '0; md4 = '0;
        init8 = 1'b0; sm8 = 1'b0; mr8 = '0; md8 = '0;

        // Reset values while rst is held.
        #1;
        check("rst_pp",   pp4,   8'h00);
        check("rst_done", done4, 1'b0);
        check("rst_busy", busy4, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned 15*15.
        run4(1'b0, 4'd15, 4'd15, lat);
        check("u15x15_pp",   pp4,   8'hE1);
        check("u15x15_lat",  lat,   5);
        check("u15x15_busy", busy4, 1'b0);
        check("u15x15_done", done4, 1'b1);

        // Result holds in DONE without init.
        repeat (3) @(negedge clk);
        check("hold_pp",   pp4,   8'hE1);
        check("hold_done", done4, 1'b1);

        // Signed boundary cases.
        run4(1'b1, 4'b1000, 4'b1000, lat);
        check("s_m8xm8_pp", pp4, 8'h40);
        run4(1'b1, 4'b1000, 4'b0111, lat);
        check("s_m8x7_pp",  pp4, 8'hC8);
        run4(1'b1, 4'b1111, 4'b0000, lat);
        check("s_m1x0_pp",  pp4, 8'h00);
        check("s_m1x0_lat", lat, 5);

        // Wider instance.
        run8(1'b0, 8'hFF, 8'hFF, lat);
        check("w8_uFFxFF_pp",  pp8, 16'hFE01);
        check("w8_uFFxFF_lat", lat, 9);
        run8(1'b1, 8'h80, 8'h80, lat);
        check("w8_s80x80_pp",  pp8, 16'h4000);

        // init and operand changes during RUN must not disturb the operation.
        @(negedge clk);
        sm4 = 1'b0; mr4 = 4'd5; md4 = 4'd6; init4 = 1'b1;
        @(negedge clk);
        check("run_busy", busy4, 1'b1);
        check("run_done", done4, 1'b0);
        init4 = 1'b1; sm4 = 1'b1; mr4 = 4'd15; md4 = 4'd15;
        @(negedge clk);
        init4 = 1'b0; mr4 = 4'd9;
        @(negedge clk);
        md4 = 4'd3;
        lat = 2;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_init_pp",  pp4, 8'd30);
        check("ignore_init_lat", lat, 5);

        // init held high: done lasts one cycle, then an immediate restart.
        @(negedge clk);
        sm4 = 1'b0; mr4 = 4'd3; md4 = 4'd2; init4 = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("held_init_pp",  pp4, 8'd6);
        check("held_init_lat", lat, 5);
        @(negedge clk);
        check("held_done_1cyc", done4, 1'b0);
        check("held_restart",   busy4, 1'b1);
        init4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("restart_pp",  pp4, 8'd6);
        check("restart_lat", lat, 5);

        // Reset in RUN aborts the operation immediately.
        @(negedge clk);
        sm4 = 1'b0; mr4 = 4'd7; md4 = 4'd7; init4 = 1'b1;
        @(negedge clk);
        init4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_pp",   pp4,   8'h00);
        check("abort_done", done4, 1'b0);
        check("abort_busy", busy4, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_no_done", done4, 1'b0);
        check("abort_no_busy", busy4, 1'b0);
        run4(1'b0, 4'd3, 4'd5, lat);
        check("post_abort_pp",  pp4, 8'd15);
        check("post_abort_lat", lat, 5);

        // init while rst is high is not accepted.
        @(negedge clk);
        rst = 1'b1; init4 = 1'b1; mr4 = 4'd2; md4 = 4'd2;
        @(negedge clk);
        rst = 1'b0; init4 = 1'b0;
        @(negedge clk);
        check("rst_init_busy", busy4, 1'b0);
        check("rst_init_done", done4, 1'b0);

        // Exhaustive sweep over both modes.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    run4(s[0], 4'(i), 4'(j), lat);
                    check("exh_pp",  pp4, ref4(s[0], 4'(i), 4'(j)));
                    check("exh_lat", lat, 5);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
